jtag_shift_chain: RTL and testbench
===================================

// Module: jtag_shift_chain
// PURPOSE
//  JTAG instruction/data register chain; sits directly downstream of state_decoder.
//  Consumes its decoded TAP-state strobes, qualified by a TCK-rising-edge enable, plus TDI.
//  Holds IR, BYPASS, IDCODE and one USER data register of DEFAULT bits, and drives TDO.
//  Fully synchronous to the system clock; TCK is represented only by tck_en.
// PARAMETERS
//  DEFAULT       32             USER data register width (>=1)
//  IR_WIDTH      4              instruction register width (>=2)
//  IDCODE_VAL    32'h1234_5001  value captured by IDCODE; bit0 must be 1
//  INSTR_IDCODE  4'b0001        opcode selecting IDCODE (also the reset instruction)
//  INSTR_USER    4'b0010        opcode selecting the USER register
// PORTS
//  clk            in   1         system clock; single clock domain
//  rst            in   1         synchronous reset, active-high
//  tck_en         in   1         1-clk strobe = TCK rising edge; decoder inputs valid
//  tdi            in   1         JTAG TDI, sampled when tck_en=1
//  tlr            in   1         TAP is in Test-Logic-Reset
//  capture_ir     in   1         decoded Capture-IR
//  shift_ir       in   1         decoded Shift-IR
//  update_ir      in   1         decoded Update-IR
//  capture_dr     in   1         decoded Capture-DR
//  shift_dr       in   1         decoded Shift-DR
//  update_dr      in   1         decoded Update-DR
//  user_capture   in   DEFAULT   parallel value loaded into USER shift reg on Capture-DR
//  ir             out  IR_WIDTH  committed instruction
//  user_dr        out  DEFAULT   last value committed by Update-DR under USER
//  user_dr_valid  out  1         1-clk pulse when user_dr is written
//  tdo            out  1         serial out: LSB of the selected shift register
//  tdo_oe         out  1         TDO enable
// BEHAVIOUR
//  - State changes only on clk edges with tck_en=1; with tck_en=0 every register holds.
//  - rst=1: ir=INSTR_IDCODE, ir_sr=0, idcode_sr=0, user_sr=0, bypass=0, user_dr=0, user_dr_valid=0.
//  - tck_en & tlr: same as rst except user_dr is kept. Partial shifts are discarded.
//  - Decoder strobes are one-hot. If several are set, priority is:
//    tlr > update_ir > capture_ir > shift_ir > update_dr > capture_dr > shift_dr.
//  - capture_ir: ir_sr <= {0.., 2'b01} (standard 01 in the LSBs).
//  - shift_ir: ir_sr <= {tdi, ir_sr[IR_WIDTH-1:1]}.
//  - update_ir: ir <= ir_sr, effective the next clk.
//  - DR select decodes the committed ir, never ir_sr:
//    IDCODE -> idcode_sr (32b); USER -> user_sr (DEFAULT b); any other opcode -> 1-bit bypass.
//  - capture_dr: selected reg loads IDCODE_VAL, user_capture, or 0 (bypass).
//  - shift_dr: selected reg <= {tdi, reg[MSB:1]}; unselected regs hold.
//  - update_dr under USER: user_dr <= user_sr; user_dr_valid=1 for exactly 1 clk.
//    Update-DR under other instructions has no effect.
//  - user_dr_valid is 0 on every other clk, including tck_en=0 clks.
//  - tdo/tdo_oe are combinational:
//    tdo_oe = shift_ir | shift_dr.
//    tdo = ir_sr[0] if shift_ir, else LSB of the selected DR, else 0.
//    The top level retimes TDO to the TCK falling edge.
//  - tdo reads the LSB before this edge's shift, so the first bit out is the captured LSB.
//  - Bypass gives a 1-TCK delay from tdi to tdo.
// STRUCTURE
//  - jtag_pkg holds IR_WIDTH, the opcode constants (IDCODE, USER, BYPASS = all ones),
//    IDCODE_VAL and the TAP state encoding shared with state_decoder.
//  - Sub-module jtag_shift_reg #(W): ports en, capture, shift, cap_val, tdi, q, lsb.
//    Instantiated for the IR, IDCODE and USER registers; bypass stays an inline flop.
// TESTING
//  1 rst=1 for 2 clks -> ir=4'b0001, user_dr=0, user_dr_valid=0, tdo_oe=0 with strobes low.
//  2 Capture-DR + 32 Shift-DR, tdi=0 -> tdo emits 0x1234_5001 LSB-first; idcode_sr ends 0.
//  3 Capture-IR, shift 4x tdi=1 -> tdo emits 1,0,0,0; update_ir -> ir=4'b1111.
//    Then DR shift of tdi 1,0,1,1 -> tdo 0,1,0,1 (bypass).
//  4 ir=USER, user_capture=0xCAFE_F00D, capture, shift tdi = 0xA5A5_5A5A LSB-first:
//    tdo emits 0xCAFE_F00D; update_dr -> user_dr=0xA5A5_5A5A, valid high 1 clk.
//  5 shift_dr held high with tck_en=0 for 10 clks -> all regs and tdo unchanged, no valid pulse.
//  6 USER selected, 10 shifts, then tlr with tck_en -> ir=4'b0001, user_sr=0, user_dr unchanged.

Source files
------------

// File: rtl/jtag_pkg.sv
// Shared JTAG constants: instruction opcodes, IDCODE value, DR select type and
// the TAP state encoding also used by state_decoder.
package jtag_pkg;

  localparam int JTAG_IR_WIDTH = 4;

  localparam logic [JTAG_IR_WIDTH-1:0] OP_IDCODE = 4'b0001;
  localparam logic [JTAG_IR_WIDTH-1:0] OP_USER   = 4'b0010;
  localparam logic [JTAG_IR_WIDTH-1:0] OP_BYPASS = 4'b1111;

  localparam logic [31:0] JTAG_IDCODE_VAL = 32'h1234_5001;

  // IEEE 1149.1 TAP state encoding
  localparam logic [3:0] TAP_TLR       = 4'hF;
  localparam logic [3:0] TAP_RTI       = 4'hC;
  localparam logic [3:0] TAP_SEL_DR    = 4'h7;
  localparam logic [3:0] TAP_CAP_DR    = 4'h6;
  localparam logic [3:0] TAP_SHIFT_DR  = 4'h2;
  localparam logic [3:0] TAP_EXIT1_DR  = 4'h1;
  localparam logic [3:0] TAP_PAUSE_DR  = 4'h3;
  localparam logic [3:0] TAP_EXIT2_DR  = 4'h0;
  localparam logic [3:0] TAP_UPD_DR    = 4'h5;
  localparam logic [3:0] TAP_SEL_IR    = 4'h4;
  localparam logic [3:0] TAP_CAP_IR    = 4'hE;
  localparam logic [3:0] TAP_SHIFT_IR  = 4'hA;
  localparam logic [3:0] TAP_EXIT1_IR  = 4'h9;
  localparam logic [3:0] TAP_PAUSE_IR  = 4'hB;
  localparam logic [3:0] TAP_EXIT2_IR  = 4'h8;
  localparam logic [3:0] TAP_UPD_IR    = 4'hD;

  typedef enum logic [1:0] {
    DR_BYPASS = 2'd0,
    DR_IDCODE = 2'd1,
    DR_USER   = 2'd2
  } dr_sel_e;

endpackage

// File: rtl/jtag_shift_chain_if.sv
// Decoded TAP strobes, TDI and user data into the shift chain; committed IR,
// user DR and TDO back out. master = TAP/decoder side, slave = shift chain.
interface jtag_shift_chain_if #(
  parameter int DEFAULT  = 32,
  parameter int IR_WIDTH = 4
);
  logic                tck_en;
  logic                tdi;
  logic                tlr;
  logic                capture_ir;
  logic                shift_ir;
  logic                update_ir;
  logic                capture_dr;
  logic                shift_dr;
  logic                update_dr;
  logic [DEFAULT-1:0]  user_capture;
  logic [IR_WIDTH-1:0] ir;
  logic [DEFAULT-1:0]  user_dr;
  logic                user_dr_valid;
  logic                tdo;
  logic                tdo_oe;

  modport master (
    output tck_en, tdi, tlr, capture_ir, shift_ir, update_ir,
           capture_dr, shift_dr, update_dr, user_capture,
    input  ir, user_dr, user_dr_valid, tdo, tdo_oe
  );

  modport slave (
    input  tck_en, tdi, tlr, capture_ir, shift_ir, update_ir,
           capture_dr, shift_dr, update_dr, user_capture,
    output ir, user_dr, user_dr_valid, tdo, tdo_oe
  );
endinterface

// File: rtl/jtag_shift_reg.sv
// Generic JTAG capture/shift register, LSB shifts out first, TDI enters at MSB.
// Updates one clk after an enabled strobe; capture wins over shift.
module jtag_shift_reg #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         capture,
  input  logic         shift,
  input  logic [W-1:0] cap_val,
  input  logic         tdi,
  output logic [W-1:0] q,
  output logic         lsb
);

  logic [W-1:0] q_q, q_d, shifted;

  generate
    if (W == 1) begin : g_one
      assign shifted = tdi;
    end else begin : g_wide
      assign shifted = {tdi, q_q[W-1:1]};
    end
  endgenerate

  always_comb begin
    q_d = q_q;
    if (en) begin
      if (capture) q_d = cap_val;
      else if (shift) q_d = shifted;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) q_q <= '0;
    else     q_q <= q_d;
  end

  assign q   = q_q;
  assign lsb = q_q[0];

endmodule

// File: rtl/jtag_shift_chain.sv
// JTAG IR / BYPASS / IDCODE / USER register chain driven by decoded TAP strobes.
// Registers step only on tck_en clks; tdo/tdo_oe are combinational, no backpressure.
module jtag_shift_chain
  import jtag_pkg::*;
#(
  parameter int                  DEFAULT      = 32,
  parameter int                  IR_WIDTH     = JTAG_IR_WIDTH,
  parameter logic [31:0]         IDCODE_VAL   = JTAG_IDCODE_VAL,
  parameter logic [IR_WIDTH-1:0] INSTR_IDCODE = OP_IDCODE,
  parameter logic [IR_WIDTH-1:0] INSTR_USER   = OP_USER
) (
  input logic               clk,
  input logic               rst,
  jtag_shift_chain_if.slave bus
);

  localparam logic [IR_WIDTH-1:0] IR_CAPTURE = IR_WIDTH'(1);

  logic do_tlr, do_uir, do_cir, do_sir, do_udr, do_cdr, do_sdr;
  logic [IR_WIDTH-1:0] ir_sr;
  logic                ir_lsb;
  logic [31:0]         id_q_unused;
  logic                id_lsb;
  logic [DEFAULT-1:0]  user_sr;
  logic                user_lsb;
  dr_sel_e             sel;

  logic [IR_WIDTH-1:0] ir_q, ir_d;
  logic                byp_q, byp_d;
  logic [DEFAULT-1:0]  udr_q, udr_d;
  logic                vld_q, vld_d;
  logic                tdo_d;

  // Resolve overlapping strobes into a one-hot set by fixed priority.
  assign do_tlr = bus.tlr;
  assign do_uir = ~do_tlr & bus.update_ir;
  assign do_cir = ~do_tlr & ~bus.update_ir & bus.capture_ir;
  assign do_sir = ~do_tlr & ~bus.update_ir & ~bus.capture_ir & bus.shift_ir;
  assign do_udr = ~do_tlr & ~bus.update_ir & ~bus.capture_ir & ~bus.shift_ir & bus.update_dr;
  assign do_cdr = ~do_tlr & ~bus.update_ir & ~bus.capture_ir & ~bus.shift_ir & ~bus.update_dr
                & bus.capture_dr;
  assign do_sdr = ~do_tlr & ~bus.update_ir & ~bus.capture_ir & ~bus.shift_ir & ~bus.update_dr
                & ~bus.capture_dr & bus.shift_dr;

  always_comb begin
    if (ir_q == INSTR_IDCODE)    sel = DR_IDCODE;
    else if (ir_q == INSTR_USER) sel = DR_USER;
    else                         sel = DR_BYPASS;
  end

  jtag_shift_reg #(.W(IR_WIDTH)) u_ir (
    .clk     (clk),
    .rst     (rst),
    .en      (bus.tck_en),
    .capture (do_tlr | do_cir),
    .shift   (do_sir),
    .cap_val (do_tlr ? '0 : IR_CAPTURE),
    .tdi     (bus.tdi),
    .q       (ir_sr),
    .lsb     (ir_lsb)
  );

  jtag_shift_reg #(.W(32)) u_idcode (
    .clk     (clk),
    .rst     (rst),
    .en      (bus.tck_en),
    .capture (do_tlr | (do_cdr & (sel == DR_IDCODE))),
    .shift   (do_sdr & (sel == DR_IDCODE)),
    .cap_val (do_tlr ? 32'd0 : IDCODE_VAL),
    .tdi     (bus.tdi),
    .q       (id_q_unused),
    .lsb     (id_lsb)
  );

  jtag_shift_reg #(.W(DEFAULT)) u_user (
    .clk     (clk),
    .rst     (rst),
    .en      (bus.tck_en),
    .capture (do_tlr | (do_cdr & (sel == DR_USER))),
    .shift   (do_sdr & (sel == DR_USER)),
    .cap_val (do_tlr ? '0 : bus.user_capture),
    .tdi     (bus.tdi),
    .q       (user_sr),
    .lsb     (user_lsb)
  );

  // TLR restores the reset instruction but deliberately keeps user_dr.
  always_comb begin
    ir_d  = ir_q;
    byp_d = byp_q;
    udr_d = udr_q;
    vld_d = 1'b0;
    if (bus.tck_en) begin
      if (do_tlr) begin
        ir_d  = INSTR_IDCODE;
        byp_d = 1'b0;
      end else if (do_uir) begin
        ir_d = ir_sr;
      end else if (do_udr && sel == DR_USER) begin
        udr_d = user_sr;
        vld_d = 1'b1;
      end else if (do_cdr && sel == DR_BYPASS) begin
        byp_d = 1'b0;
      end else if (do_sdr && sel == DR_BYPASS) begin
        byp_d = bus.tdi;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ir_q  <= INSTR_IDCODE;
      byp_q <= 1'b0;
      udr_q <= '0;
      vld_q <= 1'b0;
    end else begin
      ir_q  <= ir_d;
      byp_q <= byp_d;
      udr_q <= udr_d;
      vld_q <= vld_d;
    end
  end

  always_comb begin
    tdo_d = 1'b0;
    if (bus.shift_ir) begin
      tdo_d = ir_lsb;
    end else if (bus.shift_dr) begin
      case (sel)
        DR_IDCODE: tdo_d = id_lsb;
        DR_USER:   tdo_d = user_lsb;
        default:   tdo_d = byp_q;
      endcase
    end
  end

  assign bus.ir            = ir_q;
  assign bus.user_dr       = udr_q;
  assign bus.user_dr_valid = vld_q;
  assign bus.tdo           = tdo_d;
  assign bus.tdo_oe        = bus.shift_ir | bus.shift_dr;

endmodule

// File: tb/tb_jtag_shift_chain.sv
// Self-checking bench for jtag_shift_chain: directed scenarios plus random strobes
// checked against a register-value reference model.
module tb_jtag_shift_chain;
  import jtag_pkg::*;

  localparam int W   = 32;
  localparam int IRW = 4;

  localparam logic [6:0] S_TLR = 7'b1000000;
  localparam logic [6:0] S_UIR = 7'b0100000;
  localparam logic [6:0] S_CIR = 7'b0010000;
  localparam logic [6:0] S_SIR = 7'b0001000;
  localparam logic [6:0] S_UDR = 7'b0000100;
  localparam logic [6:0] S_CDR = 7'b0000010;
  localparam logic [6:0] S_SDR = 7'b0000001;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  jtag_shift_chain_if #(.DEFAULT(W), .IR_WIDTH(IRW)) bus ();

  jtag_shift_chain #(
    .DEFAULT      (W),
    .IR_WIDTH     (IRW),
    .IDCODE_VAL   (32'h1234_5001),
    .INSTR_IDCODE (4'b0001),
    .INSTR_USER   (4'b0010)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int errors = 0;
  int checks = 0;

  // Reference state: architectural register values only.
  logic [IRW-1:0] m_ir, m_irsr;
  logic [31:0]    m_id;
  logic [W-1:0]   m_user, m_udr;
  logic           m_byp, m_vld;

  task automatic set_in(input logic tck, input logic [6:0] s, input logic t);
    bus.tck_en = tck;
    {bus.tlr, bus.update_ir, bus.capture_ir, bus.shift_ir,
     bus.update_dr, bus.capture_dr, bus.shift_dr} = s;
    bus.tdi = t;
  endtask

  function automatic int m_sel();
    if (m_ir == 4'b0001) return 1;
    if (m_ir == 4'b0010) return 2;
    return 0;
  endfunction

  function automatic logic m_tdo();
    if (bus.shift_ir) return m_irsr[0];
    if (bus.shift_dr) begin
      case (m_sel())
        1:       return m_id[0];
        2:       return m_user[0];
        default: return m_byp;
      endcase
    end
    return 1'b0;
  endfunction

  // Advance one clk and apply the architectural rules to the model.
  task automatic clk_edge();
    int sel;
    @(posedge clk);
    sel   = m_sel();
    m_vld = 1'b0;
    if (rst) begin
      m_ir = 4'b0001; m_irsr = '0; m_id = '0; m_user = '0; m_byp = 1'b0; m_udr = '0;
    end else if (bus.tck_en) begin
      if (bus.tlr) begin
        m_ir = 4'b0001; m_irsr = '0; m_id = '0; m_user = '0; m_byp = 1'b0;
      end else if (bus.update_ir) begin
        m_ir = m_irsr;
      end else if (bus.capture_ir) begin
        m_irsr = 4'd1;
      end else if (bus.shift_ir) begin
        m_irsr = (m_irsr >> 1) + (bus.tdi ? 4'd8 : 4'd0);
      end else if (bus.update_dr) begin
        if (sel == 2) begin m_udr = m_user; m_vld = 1'b1; end
      end else if (bus.capture_dr) begin
        if (sel == 1)      m_id = 32'h1234_5001;
        else if (sel == 2) m_user = bus.user_capture;
        else               m_byp = 1'b0;
      end else if (bus.shift_dr) begin
        if (sel == 1)      m_id = (m_id >> 1) + (bus.tdi ? 32'h8000_0000 : 32'd0);
        else if (sel == 2) m_user = (m_user >> 1) + (bus.tdi ? (W'(1) << (W-1)) : '0);
        else               m_byp = bus.tdi;
      end
    end
    #1;
  endtask

  task automatic load_ir(input logic [IRW-1:0] op);
    set_in(1'b1, S_CIR, 1'b0); clk_edge();
    for (int i = 0; i < IRW; i++) begin
      set_in(1'b1, S_SIR, op[i]); clk_edge();
    end
    set_in(1'b1, S_UIR, 1'b0); clk_edge();
    set_in(1'b0, 7'd0, 1'b0);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.user_capture = '0;
    set_in(1'b0, 7'd0, 1'b0);
    clk_edge(); clk_edge();
    rst = 1'b0;
    #1;
    checks++; if (bus.ir !== 4'b0001) begin errors++; $display("FAIL reset_ir got=%h exp=1", bus.ir); end
    checks++; if (bus.user_dr !== '0) begin errors++; $display("FAIL reset_user_dr got=%h exp=0", bus.user_dr); end
    checks++; if (bus.user_dr_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", bus.user_dr_valid); end
    checks++; if (bus.tdo_oe !== 1'b0) begin errors++; $display("FAIL reset_tdo_oe got=%b exp=0", bus.tdo_oe); end
    checks++; if (bus.tdo !== 1'b0) begin errors++; $display("FAIL reset_tdo got=%b exp=0", bus.tdo); end
  endtask

  task automatic test_idcode();
    logic [31:0] got;
    int bit_err;
    got = '0;
    bit_err = 0;
    set_in(1'b1, S_CDR, 1'b0); clk_edge();
    for (int i = 0; i < 32; i++) begin
      set_in(1'b1, S_SDR, 1'b0);
      #1;
      got[i] = bus.tdo;
      if (bus.tdo !== m_tdo() || bus.tdo_oe !== 1'b1) bit_err++;
      clk_edge();
    end
    set_in(1'b0, 7'd0, 1'b0);
    checks++; if (got !== 32'h1234_5001) begin errors++; $display("FAIL idcode_word got=%h exp=12345001", got); end
    checks++; if (bit_err != 0) begin errors++; $display("FAIL idcode_bits bad_bits=%0d exp=0", bit_err); end
    checks++; if (dut.u_idcode.q_q !== 32'd0) begin errors++; $display("FAIL idcode_sr_end got=%h exp=0", dut.u_idcode.q_q); end
  endtask

  task automatic test_ir_bypass();
    logic [3:0] got;
    logic [3:0] din;
    got = '0;
    din = 4'b1101;
    set_in(1'b1, S_CIR, 1'b0); clk_edge();
    for (int i = 0; i < 4; i++) begin
      set_in(1'b1, S_SIR, 1'b1); #1; got[i] = bus.tdo; clk_edge();
    end
    checks++; if (got !== 4'b0001) begin errors++; $display("FAIL ir_capture_out got=%b exp=0001", got); end
    set_in(1'b1, S_UIR, 1'b0); clk_edge();
    checks++; if (bus.ir !== 4'b1111 || bus.ir !== m_ir) begin errors++; $display("FAIL ir_update got=%b exp=1111", bus.ir); end
    set_in(1'b1, S_CDR, 1'b0); clk_edge();
    for (int i = 0; i < 4; i++) begin
      set_in(1'b1, S_SDR, din[i]); #1; got[i] = bus.tdo; clk_edge();
    end
    set_in(1'b0, 7'd0, 1'b0);
    checks++; if (got !== 4'b1010) begin errors++; $display("FAIL bypass_out got=%b exp=1010", got); end
  endtask

  task automatic test_user();
    logic [31:0] got, din;
    got = '0;
    din = 32'hA5A5_5A5A;
    load_ir(4'b0010);
    checks++; if (bus.ir !== 4'b0010) begin errors++; $display("FAIL user_ir got=%b exp=0010", bus.ir); end
    bus.user_capture = 32'hCAFE_F00D;
    set_in(1'b1, S_CDR, 1'b0); clk_edge();
    bus.user_capture = 32'h0;
    for (int i = 0; i < 32; i++) begin
      set_in(1'b1, S_SDR, din[i]); #1; got[i] = bus.tdo; clk_edge();
    end
    checks++; if (got !== 32'hCAFE_F00D) begin errors++; $display("FAIL user_out got=%h exp=cafef00d", got); end
    checks++; if (bus.user_dr_valid !== 1'b0) begin errors++; $display("FAIL user_valid_early got=%b exp=0", bus.user_dr_valid); end
    set_in(1'b1, S_UDR, 1'b0); clk_edge();
    checks++; if (bus.user_dr_valid !== 1'b1) begin errors++; $display("FAIL user_valid got=%b exp=1", bus.user_dr_valid); end
    checks++; if (bus.user_dr !== 32'hA5A5_5A5A) begin errors++; $display("FAIL user_dr got=%h exp=a5a55a5a", bus.user_dr); end
    set_in(1'b0, 7'd0, 1'b0); clk_edge();
    checks++; if (bus.user_dr_valid !== 1'b0) begin errors++; $display("FAIL user_valid_width got=%b exp=0", bus.user_dr_valid); end
    checks++; if (bus.user_dr !== m_udr) begin errors++; $display("FAIL user_dr_hold got=%h exp=%h", bus.user_dr, m_udr); end
  endtask

  task automatic test_hold();
    logic tdo0;
    int bad;
    bad = 0;
    set_in(1'b0, S_SDR, 1'b1);
    #1;
    tdo0 = bus.tdo;
    checks++; if (tdo0 !== m_tdo()) begin errors++; $display("FAIL hold_tdo0 got=%b exp=%b", tdo0, m_tdo()); end
    for (int i = 0; i < 10; i++) begin
      bus.tdi = 1'($urandom_range(0, 1));
      clk_edge();
      if (bus.tdo !== tdo0 || bus.user_dr_valid !== 1'b0) bad++;
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL hold_outputs bad_clks=%0d exp=0", bad); end
    checks++; if (dut.u_user.q_q !== m_user || bus.ir !== m_ir) begin
      errors++; $display("FAIL hold_regs user_sr=%h exp=%h ir=%b exp=%b", dut.u_user.q_q, m_user, bus.ir, m_ir);
    end
    set_in(1'b0, 7'd0, 1'b0);
  endtask

  task automatic test_tlr();
    logic [31:0] udr0;
    udr0 = bus.user_dr;
    set_in(1'b1, S_CDR, 1'b0); clk_edge();
    for (int i = 0; i < 10; i++) begin
      set_in(1'b1, S_SDR, 1'($urandom_range(0, 1))); clk_edge();
    end
    set_in(1'b1, S_TLR, 1'b0); clk_edge();
    set_in(1'b0, 7'd0, 1'b0);
    checks++; if (bus.ir !== 4'b0001) begin errors++; $display("FAIL tlr_ir got=%b exp=0001", bus.ir); end
    checks++; if (dut.u_user.q_q !== '0) begin errors++; $display("FAIL tlr_user_sr got=%h exp=0", dut.u_user.q_q); end
    checks++; if (bus.user_dr !== udr0 || udr0 !== 32'hA5A5_5A5A) begin
      errors++; $display("FAIL tlr_user_dr got=%h exp=a5a55a5a", bus.user_dr);
    end
  endtask

  task automatic test_random();
    int bad_tdo, bad_reg;
    int r;
    logic [6:0] s;
    bad_tdo = 0;
    bad_reg = 0;
    load_ir(4'b0010);
    for (int n = 0; n < 800; n++) begin
      r = $urandom_range(0, 19);
      if (r < 6)       s = 7'(1 << r);
      else if (r < 9)  s = 7'($urandom & 32'h3F);
      else if (r == 9) s = S_TLR;
      else if (r < 12) s = S_UIR | S_SDR;
      else             s = S_SDR;
      bus.user_capture = $urandom;
      set_in(1'($urandom_range(0, 9) < 7), s, 1'($urandom_range(0, 1)));
      #1;
      if (bus.tdo !== m_tdo() || bus.tdo_oe !== (bus.shift_ir | bus.shift_dr)) bad_tdo++;
      clk_edge();
      if (bus.ir !== m_ir || bus.user_dr !== m_udr || bus.user_dr_valid !== m_vld) bad_reg++;
    end
    set_in(1'b0, 7'd0, 1'b0);
    checks++; if (bad_tdo != 0) begin errors++; $display("FAIL random_tdo bad_clks=%0d exp=0", bad_tdo); end
    checks++; if (bad_reg != 0) begin errors++; $display("FAIL random_regs bad_clks=%0d exp=0", bad_reg); end
  endtask

  initial begin
    test_reset();
    test_idcode();
    test_ir_bypass();
    test_user();
    test_hold();
    test_tlr();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
